smc_loop_scheduler: RTL and testbench

Sequences one control period of the combinational sliding-mode controller datapath. A free-running period timer triggers each control tick. On a tick the block:
- requests and latches a sensor sample (theta, dtheta) and holds it stable on the datapath inputs;
- waits a fixed settle time, then captures and saturates the datapath output u;
- pulses the datapath start strobe so it registers u as its feedback term;
- hands the saturated command to the actuator interface over a valid/ready handshake.

---
 rtl/smc_loop_scheduler_if.sv | 24 ++
 rtl/smc_loop_scheduler.sv | 151 +++++++++++++++
 tb/tb_smc_loop_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/smc_loop_scheduler_if.sv
// Sensor, datapath and actuator signals between the SMC loop scheduler and its environment.
interface smc_loop_scheduler_if;
    logic        sens_req;
    logic        sens_ack;
    logic [31:0] theta_in;
    logic [31:0] dtheta_in;
    logic [31:0] theta_o;
    logic [31:0] dtheta_o;
    logic        start;
    logic [15:0] u_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_u;

    modport master (
        output sens_req, theta_o, dtheta_o, start, cmd_valid, cmd_u,
        input  sens_ack, theta_in, dtheta_in, u_in, cmd_ready
    );

    modport slave (
        input  sens_req, theta_o, dtheta_o, start, cmd_valid, cmd_u,
        output sens_ack, theta_in, dtheta_in, u_in, cmd_ready
    );
endinterface

// File: rtl/smc_loop_scheduler.sv
// Control-period sequencer for the combinational sliding-mode controller datapath:
// tick -> sample -> settle -> capture/saturate u -> hand command to the actuator.
module smc_loop_scheduler #(
    parameter int PERIOD = 50000,
    parameter int SETTLE = 8,
    parameter int U_MAX  = 2000,
    parameter int WDOG   = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    smc_loop_scheduler_if.master        bus,
    output logic                        sat,
    output logic                        overrun,
    output logic                        fault
);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0]      L_TMAX   = TW'(PERIOD - 1);
    localparam logic [15:0]        L_WDLAST = 16'(WDOG - 1);
    localparam logic [15:0]        L_STLAST = 16'(SETTLE - 1);
    localparam logic signed [15:0] L_UPOS   = 16'(U_MAX);
    localparam logic signed [15:0] L_UNEG   = 16'(-U_MAX);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;
    localparam logic [2:0] S_ISSUE  = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [TW-1:0]      r_timer;
    logic [15:0]        r_cnt;
    logic               r_sens_req;
    logic               r_start;
    logic               r_cmd_valid;
    logic               r_sat;
    logic               r_overrun;
    logic               r_fault;
    logic [31:0]        r_theta;
    logic [31:0]        r_dtheta;
    logic [15:0]        r_cmd_u;
    logic               w_run;
    logic               w_tick;
    logic               w_busy;
    logic               w_u_hi;
    logic               w_u_lo;
    logic signed [15:0] w_u;
    logic signed [15:0] w_u_clamped;

    assign w_run  = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign w_tick = w_run && (r_timer == L_TMAX);
    assign w_busy = (r_state == S_SAMPLE) || (r_state == S_SETTLE) ||
                    (r_state == S_LATCH)  || (r_state == S_ISSUE);

    assign w_u         = bus.u_in;
    assign w_u_hi      = w_u > L_UPOS;
    assign w_u_lo      = w_u < L_UNEG;
    assign w_u_clamped = w_u_hi ? L_UPOS : (w_u_lo ? L_UNEG : w_u);

    // A sample ack always wins over a watchdog expiry in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_next = S_WAIT;
            S_WAIT: begin
                if (!enable)     w_next = S_IDLE;
                else if (w_tick) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (bus.sens_ack)           w_next = S_SETTLE;
                else if (r_cnt == L_WDLAST) w_next = S_FAULT;
            end
            S_SETTLE: if (r_cnt == L_STLAST) w_next = S_LATCH;
            S_LATCH:  w_next = S_ISSUE;
            S_ISSUE:  if (bus.cmd_ready) w_next = enable ? S_WAIT : S_IDLE;
            S_FAULT:  if (!enable) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_sens_req  <= 1'b0;
            r_start     <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_overrun   <= 1'b0;
            r_fault     <= 1'b0;
            r_theta     <= '0;
            r_dtheta    <= '0;
            r_cmd_u     <= '0;
        end else begin
            r_state <= w_next;

            // Timer reads 0 in IDLE/FAULT so the first WAIT_TICK cycle starts a full period.
            if (!w_run || (w_next == S_IDLE) || (w_next == S_FAULT))
                r_timer <= '0;
            else if (r_timer == L_TMAX)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);

            if (w_next != r_state)
                r_cnt <= '0;
            else if ((r_state == S_SAMPLE) || (r_state == S_SETTLE))
                r_cnt <= r_cnt + 16'd1;

            r_sens_req  <= (w_next == S_SAMPLE);
            r_start     <= (r_state == S_SETTLE) && (w_next == S_LATCH);
            r_cmd_valid <= (w_next == S_ISSUE);

            if ((r_state == S_SAMPLE) && bus.sens_ack) begin
                r_theta  <= bus.theta_in;
                r_dtheta <= bus.dtheta_in;
            end

            if (r_state == S_LATCH) begin
                r_cmd_u <= w_u_clamped;
                r_sat   <= w_u_hi || w_u_lo;
            end else if ((r_state == S_SAMPLE) && (w_next == S_FAULT)) begin
                r_cmd_u <= '0;
            end

            if ((r_state == S_SAMPLE) && (w_next == S_FAULT))
                r_fault <= 1'b1;
            else if ((r_state == S_FAULT) && (w_next == S_IDLE))
                r_fault <= 1'b0;

            if ((r_state == S_FAULT) && (w_next == S_IDLE))
                r_overrun <= 1'b0;
            else if (w_tick && w_busy)
                r_overrun <= 1'b1;
        end
    end

    assign bus.sens_req  = r_sens_req;
    assign bus.theta_o   = r_theta;
    assign bus.dtheta_o  = r_dtheta;
    assign bus.start     = r_start;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_u     = r_cmd_u;
    assign sat           = r_sat;
    assign overrun       = r_overrun;
    assign fault         = r_fault;
endmodule

// File: tb/tb_smc_loop_scheduler.sv
// Self-checking bench for smc_loop_scheduler: directed and randomized control periods
// checked against period/latency arithmetic and a clamp model.
module tb_smc_loop_scheduler;
    localparam int PERIOD = 40;
    localparam int SETTLE = 8;
    localparam int U_MAX  = 2000;
    localparam int WDOG   = 20;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic sat;
    logic overrun;
    logic fault;

    smc_loop_scheduler_if bus();

    smc_loop_scheduler #(
        .PERIOD(PERIOD),
        .SETTLE(SETTLE),
        .U_MAX (U_MAX),
        .WDOG  (WDOG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus),
        .sat    (sat),
        .overrun(overrun),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;
    int   expReq     = 0;
    bit   expOverrun = 1'b0;
    int   startCount = 0;
    int   validRises = 0;
    logic prevValid  = 1'b0;

    always @(negedge clk) begin
        if (bus.start === 1'b1) startCount <= startCount + 1;
        if ((bus.cmd_valid === 1'b1) && (prevValid !== 1'b1)) validRises <= validRises + 1;
        prevValid <= bus.cmd_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic int clampU(input int u);
        if (u > U_MAX)  return U_MAX;
        if (u < -U_MAX) return -U_MAX;
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] th, input logic [31:0] dth);
        bus.sens_ack  = ack;
        bus.theta_in  = th;
        bus.dtheta_in = dth;
    endtask

    task automatic waitReq(output int at);
        int budget;
        budget = 3 * PERIOD;
        while ((bus.sens_req !== 1'b1) && (budget > 0)) begin
            step();
            budget--;
        end
        at = cyc;
        checkOutput("req_seen", bus.sens_req, 1);
    endtask

    // One control period: ack after ackDelay cycles of req, ready after readyDelay cycles of valid.
    task automatic runPeriod(input int u, input int ackDelay, input int readyDelay, input bit dropEn);
        int          reqAt;
        int          ackAt;
        int          startAt;
        int          accAt;
        int          budget;
        int          nextTick;
        logic [31:0] th;
        logic [31:0] dth;
        logic [15:0] expU;
        bit          expSat;
        waitReq(reqAt);
        checkOutput("req_cycle", reqAt, expReq);
        bus.u_in = 16'(u);
        if (dropEn) enable = 1'b0;
        for (int i = 0; i < ackDelay; i++) begin
            step();
            checkOutput("req_held", bus.sens_req, 1);
        end
        ackAt = cyc;
        th    = $urandom;
        dth   = $urandom;
        applyStimulus(1'b1, th, dth);
        step();
        applyStimulus(1'b1, ~th, ~dth);
        checkOutput("req_drop", bus.sens_req, 0);
        checkOutput("theta_latch", bus.theta_o, th);
        checkOutput("dtheta_latch", bus.dtheta_o, dth);
        step();
        applyStimulus(1'b0, $urandom, $urandom);
        checkOutput("theta_hold", bus.theta_o, th);
        checkOutput("dtheta_hold", bus.dtheta_o, dth);
        budget = 4 * SETTLE;
        while ((bus.start !== 1'b1) && (budget > 0)) begin
            step();
            budget--;
        end
        startAt = cyc;
        checkOutput("start_cycle", startAt, ackAt + SETTLE + 1);
        checkOutput("valid_before_start", bus.cmd_valid, 0);
        expU   = 16'(clampU(u));
        expSat = (u > U_MAX) || (u < -U_MAX);
        step();
        checkOutput("start_width", bus.start, 0);
        checkOutput("valid_rise", bus.cmd_valid, 1);
        checkOutput("cmd_u", bus.cmd_u, expU);
        checkOutput("sat", sat, expSat);
        for (int i = 0; i < readyDelay; i++) begin
            step();
            checkOutput("valid_held", bus.cmd_valid, 1);
            checkOutput("cmd_u_held", bus.cmd_u, expU);
            checkOutput("overrun_live", overrun, expOverrun || (cyc >= reqAt + PERIOD));
        end
        accAt = cyc;
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        checkOutput("valid_fall", bus.cmd_valid, 0);
        if (reqAt - 1 + PERIOD <= accAt) expOverrun = 1'b1;
        checkOutput("overrun", overrun, expOverrun);
        nextTick = reqAt - 1 + PERIOD;
        while (nextTick < accAt + 1) nextTick += PERIOD;
        expReq = nextTick + 1;
    endtask

    task automatic runWatchdog();
        int reqAt;
        int startsBefore;
        bit reqSeen;
        waitReq(reqAt);
        checkOutput("wd_req_cycle", reqAt, expReq);
        startsBefore = startCount;
        while (cyc < reqAt + WDOG - 1) step();
        checkOutput("wd_fault_early", fault, 0);
        checkOutput("wd_req_early", bus.sens_req, 1);
        step();
        checkOutput("wd_fault", fault, 1);
        checkOutput("wd_req_off", bus.sens_req, 0);
        checkOutput("wd_cmd_u", bus.cmd_u, 0);
        checkOutput("wd_valid", bus.cmd_valid, 0);
        reqSeen = 1'b0;
        repeat (2 * PERIOD) begin
            step();
            if (bus.sens_req === 1'b1) reqSeen = 1'b1;
        end
        checkOutput("wd_no_req", reqSeen, 0);
        checkOutput("wd_fault_sticky", fault, 1);
        checkOutput("wd_no_start", startCount - startsBefore, 0);
        enable = 1'b0;
        step();
        expOverrun = 1'b0;
        checkOutput("wd_fault_clear", fault, 0);
        checkOutput("wd_overrun_clear", overrun, 0);
        enable = 1'b1;
        expReq = cyc + 1 + PERIOD;
    endtask

    int satU [4] = '{3000, -3000, 2000, -2001};

    initial begin
        int          reqAt;
        int          validBefore;
        bit          reqSeen;
        logic [31:0] th;
        rst = 1'b1;
        enable = 1'b0;
        bus.u_in = '0;
        bus.cmd_ready = 1'b0;
        applyStimulus(1'b0, '0, '0);
        step();
        step();
        checkOutput("rst_sens_req", bus.sens_req, 0);
        checkOutput("rst_start", bus.start, 0);
        checkOutput("rst_cmd_valid", bus.cmd_valid, 0);
        checkOutput("rst_cmd_u", bus.cmd_u, 0);
        checkOutput("rst_theta", bus.theta_o, 0);
        checkOutput("rst_flags", {sat, overrun, fault}, 0);
        rst = 1'b0;
        step();
        step();
        checkOutput("idle_no_req", bus.sens_req, 0);

        $display("[TB] nominal periods");
        enable = 1'b1;
        expReq = cyc + 1 + PERIOD;
        repeat (3) runPeriod(500, 0, 0, 1'b0);

        $display("[TB] saturation");
        for (int i = 0; i < 4; i++) runPeriod(satU[i], 0, 0, 1'b0);

        $display("[TB] randomized periods");
        for (int i = 0; i < 10; i++)
            runPeriod(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 6)), 1'b0);

        $display("[TB] stalled actuator");
        runPeriod(1234, 0, 50, 1'b0);
        runPeriod(-321, 1, 2, 1'b0);

        $display("[TB] sensor watchdog");
        runWatchdog();
        runPeriod(42, 0, 0, 1'b0);

        $display("[TB] enable dropped in SAMPLE");
        validBefore = validRises;
        runPeriod(777, 2, 1, 1'b1);
        reqSeen = 1'b0;
        repeat (2 * PERIOD + 5) begin
            step();
            if (bus.sens_req === 1'b1) reqSeen = 1'b1;
        end
        checkOutput("en_drop_no_req", reqSeen, 0);
        checkOutput("en_drop_one_cmd", validRises - validBefore, 1);
        enable = 1'b1;
        expReq = cyc + 1 + PERIOD;
        runPeriod(600, 0, 0, 1'b0);

        $display("[TB] reset during SETTLE");
        waitReq(reqAt);
        checkOutput("mr_req_cycle", reqAt, expReq);
        th = $urandom | 32'h1;
        applyStimulus(1'b1, th, ~th);
        step();
        applyStimulus(1'b0, '0, '0);
        checkOutput("mr_theta_latched", bus.theta_o, th);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checkOutput("mr_theta", bus.theta_o, 0);
        checkOutput("mr_dtheta", bus.dtheta_o, 0);
        checkOutput("mr_cmd_u", bus.cmd_u, 0);
        checkOutput("mr_handshake", {bus.sens_req, bus.start, bus.cmd_valid}, 0);
        checkOutput("mr_flags", {sat, overrun, fault}, 0);
        step();
        step();
        rst = 1'b0;
        expOverrun = 1'b0;
        expReq = cyc + 1 + PERIOD;
        runPeriod(-2500, 0, 0, 1'b0);
        runPeriod(100, 3, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
